// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 18;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CNT_HI = 4'd1,
    ST_CNT_LO = 4'd2,
    ST_W2     = 4'd3,
    ST_W1     = 4'd4,
    ST_W0     = 4'd5,
    ST_CHK    = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Frames a UART byte stream into 18-bit program RAM writes; holds the MCU in
// reset while loading and keeps it there if the image is bad.
//
// state  | meaning
// IDLE   | waiting for header byte
// CNT_HI | expecting word count high byte
// CNT_LO | expecting word count low byte, range-checked on arrival
// W2     | expecting word bits [17:16]
// W1     | expecting word bits [15:8]
// W0     | expecting word bits [7:0], write issued on arrival
// CHK    | expecting XOR checksum byte
// DONE   | frame good, one cycle, then IDLE
// ERR    | frame aborted/bad, one cycle, then IDLE
import prog_loader_pkg::*;

module prog_loader #(
  parameter int         DEPTH          = 1024,
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0] HDR_BYTE       = HDR_BYTE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               prog_we,
  output logic [ADDR_W-1:0]  prog_addr,
  output logic [INSTR_W-1:0] prog_din,
  output logic               mcu_rst,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err
);

  localparam int           TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [15:0]        cnt_q;
  logic [1:0]         b2_q;
  logic [7:0]         b1_q;
  logic [7:0]         acc_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [TMR_W-1:0]   tmr_q;

  logic        active;
  logic        timeout;
  logic [15:0] cnt_new;

  assign active  = (state == ST_CNT_HI) || (state == ST_CNT_LO) || (state == ST_W2) ||
                   (state == ST_W1) || (state == ST_W0) || (state == ST_CHK);
  // A byte landing on the terminal cycle wins over the timeout.
  assign timeout = active && !rx_valid && (tmr_q == '0);
  assign cnt_new = {cnt_q[15:8], rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt_q     <= '0;
      b2_q      <= '0;
      b1_q      <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_din  <= '0;
      mcu_rst   <= 1'b0;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      prog_we <= 1'b0;

      if (rx_valid)
        tmr_q <= TMR_LOAD;
      else if (active && tmr_q != '0)
        tmr_q <= tmr_q - 1'b1;

      if (rx_valid && active)
        acc_q <= acc_q ^ rx_data;

      if (timeout) begin
        state     <= ST_ERR;
        load_busy <= 1'b0;
        load_err  <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          ST_CNT_HI: begin
            cnt_q[15:8] <= rx_data;
            state       <= ST_CNT_LO;
          end
          ST_CNT_LO: begin
            cnt_q[7:0] <= rx_data;
            if (cnt_new == 16'd0 || cnt_new > 16'(DEPTH)) begin
              state     <= ST_ERR;
              load_busy <= 1'b0;
              load_err  <= 1'b1;
            end else begin
              state <= ST_W2;
            end
          end
          ST_W2: begin
            b2_q  <= rx_data[1:0];
            state <= ST_W1;
          end
          ST_W1: begin
            b1_q  <= rx_data;
            state <= ST_W0;
          end
          ST_W0: begin
            prog_we   <= 1'b1;
            prog_addr <= idx_q;
            prog_din  <= {b2_q, b1_q, rx_data};
            idx_q     <= idx_q + 1'b1;
            state     <= (16'(idx_q) + 16'd1 == cnt_q) ? ST_CHK : ST_W2;
          end
          ST_CHK: begin
            load_busy <= 1'b0;
            if ((acc_q ^ rx_data) == 8'h00) begin
              state     <= ST_DONE;
              mcu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= ST_ERR;
              load_err <= 1'b1;
            end
          end
          default: begin
            if (rx_data == HDR_BYTE) begin
              state     <= ST_CNT_HI;
              mcu_rst   <= 1'b1;
              load_busy <= 1'b1;
              load_done <= 1'b0;
              load_err  <= 1'b0;
              acc_q     <= '0;
              idx_q     <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        endcase
      end else if (state == ST_DONE || state == ST_ERR) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule
